// File: rtl/fc_stream_pkg.sv
// Shared definitions for the int8 fully-connected stream engine.
//   - FSM state encoding (LOAD_IN, LOAD_W, LOAD_B, COMPUTE, OUTPUT)
//   - sizing helpers: accumulator width and words per stream section
//   - sat8: clamp a sign-extended 32-bit value to the int8 range
package fc_stream_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_LOAD_IN = 3'd0;
    localparam state_t ST_LOAD_W  = 3'd1;
    localparam state_t ST_LOAD_B  = 3'd2;
    localparam state_t ST_COMPUTE = 3'd3;
    localparam state_t ST_OUTPUT  = 3'd4;

    // 16 bits of product, log2(IN_SIZE) bits of growth, one guard bit
    // so the bias add can never wrap.
    function automatic int acc_w(input int in_size);
        return 16 + $clog2(in_size) + 1;
    endfunction

    function automatic int in_words(input int in_size);
        return in_size / 4;
    endfunction

    function automatic int w_words(input int in_size, input int out_size);
        return (in_size * out_size) / 4;
    endfunction

    function automatic int b_words(input int out_size);
        return out_size / 4;
    endfunction

    function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127)
            return 8'sd127;
        else if (v < -32'sd128)
            return -8'sd128;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/fc_stream_engine_mac.sv
// fc_mac: sequential signed 8x8 multiply-accumulate for one neuron at a time.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   mac_en           an x*w product is issued this cycle
//   mac_last         the issued product is the last one of the neuron
//   x_in, w_in, b_in int8 operand, weight and bias of the current neuron
//   res_vld          res_out holds a finished neuron result this cycle
//   res_out          (sum + bias) >>> SHIFT, saturated to int8
// Build option: define RELU_EN to clamp negative results to zero.
module fc_mac
    import fc_stream_pkg::*;
#(
    parameter int IN_SIZE = 8,
    parameter int SHIFT   = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       mac_en,
    input  logic       mac_last,
    input  logic [7:0] x_in,
    input  logic [7:0] w_in,
    input  logic [7:0] b_in,
    output logic       res_vld,
    output logic [7:0] res_out
);

    localparam int ACC_W = acc_w(IN_SIZE);

    logic signed [15:0]      xe, we;
    logic signed [15:0]      prod_p0;
    logic signed [7:0]       bias_p0;
    logic                    vld_p0, last_p0;
    logic signed [ACC_W-1:0] acc_p1, sum_p1, fin_p1;

    // Shift first, then saturate, so large sums still scale correctly.
    function automatic logic [7:0] finalize(input logic signed [ACC_W-1:0] v);
        logic signed [31:0] shf;
        logic [7:0]         s;
        shf = 32'(v) >>> SHIFT;
        s   = sat8(shf);
`ifdef RELU_EN
        if (s[7])
            s = 8'h00;
`endif
        return s;
    endfunction

    assign xe = {{8{x_in[7]}}, x_in};
    assign we = {{8{w_in[7]}}, w_in};

    // ---- stage p0: product register ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            vld_p0  <= mac_en;
            last_p0 <= mac_en & mac_last;
        end
    end

    always_ff @(posedge clk) begin
        prod_p0 <= xe * we;
        bias_p0 <= b_in;
    end

    // ---- stage p1: accumulate; bias joins the final sum of a neuron ----
    assign sum_p1 = acc_p1 + ACC_W'(prod_p0);
    assign fin_p1 = sum_p1 + ACC_W'(bias_p0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            acc_p1 <= '0;
        else if (vld_p0)
            acc_p1 <= last_p0 ? '0 : sum_p1;
    end

    assign res_vld = vld_p0 & last_p0;
    assign res_out = finalize(fin_p1);

endmodule

// File: rtl/fc_stream_engine.sv
// fc_stream_engine: int8 fully-connected layer engine on a word stream.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   r_valid/r_ready    input stream handshake; in_data is little-endian
//   in_data[31:0]      x words, then row-major weight words, then bias words
//   t_valid/t_ready    output stream handshake with backpressure
//   out_data[31:0]     four int8 results, lowest index in bits [7:0]
//   busy               high while computing or presenting results
// Build option: RELU_EN (see fc_mac) clamps negative results to zero.
// Buffers are shift registers: loading shifts words in from the top, so the
// first stream byte ends at bits [7:0]; compute rotates them byte by byte so
// the current operand is always the low byte.
module fc_stream_engine
    import fc_stream_pkg::*;
#(
    parameter int IN_SIZE  = 8,
    parameter int OUT_SIZE = 4,
    parameter int SHIFT    = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [31:0] in_data,
    output logic        t_valid,
    input  logic        t_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int MACS  = IN_SIZE * OUT_SIZE;
    localparam int CNT_W = $clog2(MACS) + 1;
    localparam int XW    = IN_SIZE * 8;
    localparam int WW    = MACS * 8;
    localparam int BW    = OUT_SIZE * 8;

    localparam logic [CNT_W-1:0] IN_LAST = CNT_W'(in_words(IN_SIZE) - 1);
    localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(w_words(IN_SIZE, OUT_SIZE) - 1);
    localparam logic [CNT_W-1:0] B_LAST  = CNT_W'(b_words(OUT_SIZE) - 1);
    localparam logic [CNT_W-1:0] I_LAST  = CNT_W'(IN_SIZE - 1);
    localparam logic [CNT_W-1:0] M_LAST  = CNT_W'(MACS - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    logic             run_q;
    logic [CNT_W-1:0] wcnt, mcnt, i_idx, ocnt;
    logic             issue_done;
    logic [XW-1:0]    x_vec;
    logic [WW-1:0]    w_vec;
    logic [BW-1:0]    b_vec, r_vec;
    logic             in_hs, out_hs, mac_en, mac_last, res_vld;
    logic [7:0]       res_out;

    // run_q keeps r_ready low while reset is held and for no longer.
    assign r_ready  = run_q & ((state == ST_LOAD_IN) | (state == ST_LOAD_W) |
                               (state == ST_LOAD_B));
    assign t_valid  = (state == ST_OUTPUT);
    assign busy     = (state == ST_COMPUTE) | (state == ST_OUTPUT);
    assign out_data = t_valid ? r_vec[31:0] : 32'h0;
    assign in_hs    = r_valid & r_ready;
    assign out_hs   = t_valid & t_ready;
    assign mac_en   = (state == ST_COMPUTE) & ~issue_done;
    assign mac_last = (i_idx == I_LAST);

    fc_mac #(.IN_SIZE(IN_SIZE), .SHIFT(SHIFT)) u_mac (
        .clk      (clk),
        .rstn     (rstn),
        .mac_en   (mac_en),
        .mac_last (mac_last),
        .x_in     (x_vec[7:0]),
        .w_in     (w_vec[7:0]),
        .b_in     (b_vec[7:0]),
        .res_vld  (res_vld),
        .res_out  (res_out)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_LOAD_IN;
            run_q      <= 1'b0;
            wcnt       <= '0;
            mcnt       <= '0;
            i_idx      <= '0;
            ocnt       <= '0;
            issue_done <= 1'b0;
            x_vec      <= '0;
            w_vec      <= '0;
            b_vec      <= '0;
            r_vec      <= '0;
        end else begin
            run_q <= 1'b1;
            case (state)
                ST_LOAD_IN: if (in_hs) begin
                    x_vec <= XW'({in_data, x_vec} >> 32);
                    if (wcnt == IN_LAST) begin
                        wcnt  <= '0;
                        state <= ST_LOAD_W;
                    end else
                        wcnt <= wcnt + ONE;
                end
                ST_LOAD_W: if (in_hs) begin
                    w_vec <= WW'({in_data, w_vec} >> 32);
                    if (wcnt == W_LAST) begin
                        wcnt  <= '0;
                        state <= ST_LOAD_B;
                    end else
                        wcnt <= wcnt + ONE;
                end
                ST_LOAD_B: if (in_hs) begin
                    b_vec <= BW'({in_data, b_vec} >> 32);
                    if (wcnt == B_LAST) begin
                        wcnt       <= '0;
                        mcnt       <= '0;
                        i_idx      <= '0;
                        issue_done <= 1'b0;
                        state      <= ST_COMPUTE;
                    end else
                        wcnt <= wcnt + ONE;
                end
                ST_COMPUTE: begin
                    if (mac_en) begin
                        x_vec <= {x_vec[7:0], x_vec[XW-1:8]};
                        w_vec <= {w_vec[7:0], w_vec[WW-1:8]};
                        if (mac_last) begin
                            b_vec <= {b_vec[7:0], b_vec[BW-1:8]};
                            i_idx <= '0;
                        end else
                            i_idx <= i_idx + ONE;
                        if (mcnt == M_LAST)
                            issue_done <= 1'b1;
                        else
                            mcnt <= mcnt + ONE;
                    end
                    // Results arrive one cycle behind issue; the one seen
                    // after issue has finished belongs to the last neuron.
                    if (res_vld) begin
                        r_vec <= {res_out, r_vec[BW-1:8]};
                        if (issue_done) begin
                            ocnt  <= '0;
                            state <= ST_OUTPUT;
                        end
                    end
                end
                ST_OUTPUT: if (out_hs) begin
                    r_vec <= r_vec >> 32;
                    if (ocnt == B_LAST) begin
                        ocnt  <= '0;
                        state <= ST_LOAD_IN;
                    end else
                        ocnt <= ocnt + ONE;
                end
                default: state <= ST_LOAD_IN;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_stream_engine.sv
module tb_fc_stream_engine;

    logic        clk, rstn;
    logic [2:0]  r_valid, r_ready, t_valid, t_ready, busy;
    logic [31:0] in_data  [3];
    logic [31:0] out_data [3];
    logic [31:0] exp_q [3][$];
    logic [7:0]  fx [8];
    logic [7:0]  fw [64];
    logic [7:0]  fb [8];
    int          checks = 0;
    int          errors = 0;

    // d0: defaults; d1: SHIFT=4; d2: OUT_SIZE=8
    fc_stream_engine #(.IN_SIZE(8), .OUT_SIZE(4), .SHIFT(0)) u_d0 (
        .clk(clk), .rstn(rstn), .r_valid(r_valid[0]), .r_ready(r_ready[0]),
        .in_data(in_data[0]), .t_valid(t_valid[0]), .t_ready(t_ready[0]),
        .out_data(out_data[0]), .busy(busy[0]));
    fc_stream_engine #(.IN_SIZE(8), .OUT_SIZE(4), .SHIFT(4)) u_d1 (
        .clk(clk), .rstn(rstn), .r_valid(r_valid[1]), .r_ready(r_ready[1]),
        .in_data(in_data[1]), .t_valid(t_valid[1]), .t_ready(t_ready[1]),
        .out_data(out_data[1]), .busy(busy[1]));
    fc_stream_engine #(.IN_SIZE(8), .OUT_SIZE(8), .SHIFT(0)) u_d2 (
        .clk(clk), .rstn(rstn), .r_valid(r_valid[2]), .r_ready(r_ready[2]),
        .in_data(in_data[2]), .t_valid(t_valid[2]), .t_ready(t_ready[2]),
        .out_data(out_data[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int d, input logic [31:0] w);
        bit hs;
        int tries;
        in_data[d] = w;
        r_valid[d] = 1'b1;
        tries = 0;
        do begin
            @(negedge clk);
            hs = r_ready[d];
            tick();
            tries++;
        end while (!hs && tries < 200);
        if (!hs)
            check($sformatf("r_ready timeout d%0d", d), 32'(hs), 32'd1);
    endtask

    task automatic send_frame(input int d, input int outsz, input bit gaps);
        logic [31:0] words[$];
        for (int k = 0; k < 8; k += 4)
            words.push_back({fx[k+3], fx[k+2], fx[k+1], fx[k]});
        for (int k = 0; k < 8 * outsz; k += 4)
            words.push_back({fw[k+3], fw[k+2], fw[k+1], fw[k]});
        for (int k = 0; k < outsz; k += 4)
            words.push_back({fb[k+3], fb[k+2], fb[k+1], fb[k]});
        foreach (words[n]) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                r_valid[d] = 1'b0;
                in_data[d] = 32'hDEADBEEF;
                repeat ($urandom_range(1, 3)) tick();
            end
            send_word(d, words[n]);
        end
        r_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while ((exp_q[d].size() != 0 || t_valid[d]) && n < 400) begin
            tick();
            n++;
        end
        check($sformatf("drain d%0d", d), 32'(exp_q[d].size()) | 32'(t_valid[d]), 32'd0);
    endtask

    task automatic fill(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b);
        foreach (fx[i]) fx[i] = x;
        foreach (fw[i]) fw[i] = w;
        foreach (fb[i]) fb[i] = b;
    endtask

    task automatic fill_mixed();
        logic [7:0] rowv [4];
        rowv[0] = 8'h01; rowv[1] = 8'hFF; rowv[2] = 8'h02; rowv[3] = 8'h00;
        for (int i = 0; i < 8; i++) fx[i] = 8'(i + 1);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 8; i++) fw[j*8+i] = rowv[j];
        fb[0] = 8'h05; fb[1] = 8'h10; fb[2] = 8'hF8; fb[3] = 8'hFE;
    endtask

    // Monitor: compares every accepted output word with the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rstn && t_valid[d] && t_ready[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word d%0d: got 0x%08h, no result expected", d, out_data[d]);
                    end else
                        check($sformatf("out_word d%0d", d), out_data[d], exp_q[d].pop_front());
                end
            end
        end
    end

    initial begin
        int         cyc, hs, n;
        bit         rr_bad, busy_bad, stable_bad;
        logic [31:0] cap;
        logic [31:0] mixed_exp, neg_exp, neg1_exp;
`ifdef RELU_EN
        mixed_exp = 32'h00400029;
        neg_exp   = 32'h00000000;
        neg1_exp  = 32'h00000000;
`else
        mixed_exp = 32'hFE40EC29;
        neg_exp   = 32'h80808080;
        neg1_exp  = 32'hFFFFFFFF;
`endif
        rstn    = 1'b0;
        r_valid = 3'b000;
        t_ready = 3'b111;
        for (int d = 0; d < 3; d++) in_data[d] = 32'h0;

        // reset state
        repeat (3) tick();
        check("reset r_ready", 32'(r_ready[0]), 32'd0);
        check("reset t_valid", 32'(t_valid[0]), 32'd0);
        check("reset busy", 32'(busy[0]), 32'd0);
        check("reset out_data", out_data[0], 32'h0);
        rstn = 1'b1;
        tick();
        check("r_ready after release", 32'(r_ready[0]), 32'd1);

        // all ones: latency, r_ready low and junk ignored during compute
        fill(8'h01, 8'h01, 8'h00);
        exp_q[0].push_back(32'h08080808);
        send_frame(0, 4, 0);
        r_valid[0] = 1'b1;
        in_data[0] = 32'h5A5A5A5A;
        cyc = 0; rr_bad = 0; busy_bad = 0;
        while (!t_valid[0] && cyc < 100) begin
            if (r_ready[0]) rr_bad = 1;
            if (!busy[0]) busy_bad = 1;
            tick();
            cyc++;
        end
        r_valid[0] = 1'b0;
        check("first t_valid latency", 32'(cyc), 32'd33);
        check("r_ready low in compute", 32'(rr_bad), 32'd0);
        check("busy high in compute", 32'(busy_bad), 32'd0);
        wait_idle(0);

        // positive saturation, negative saturation, mixed signs, gapped load
        fill(8'h7F, 8'h7F, 8'h7F);
        exp_q[0].push_back(32'h7F7F7F7F);
        send_frame(0, 4, 0);
        wait_idle(0);
        fill(8'h80, 8'h7F, 8'h00);
        exp_q[0].push_back(neg_exp);
        send_frame(0, 4, 0);
        wait_idle(0);
        fill_mixed();
        exp_q[0].push_back(mixed_exp);
        send_frame(0, 4, 0);
        wait_idle(0);
        exp_q[0].push_back(mixed_exp);
        send_frame(0, 4, 1);
        wait_idle(0);

        // reset after 3 weight words, then a complete frame
        fill(8'h7F, 8'h7F, 8'h7F);
        send_word(0, {fx[3], fx[2], fx[1], fx[0]});
        send_word(0, {fx[7], fx[6], fx[5], fx[4]});
        for (int k = 0; k < 12; k += 4)
            send_word(0, {fw[k+3], fw[k+2], fw[k+1], fw[k]});
        r_valid[0] = 1'b0;
        rstn = 1'b0;
        #1;
        check("mid-load reset r_ready", 32'(r_ready[0]), 32'd0);
        check("mid-load reset busy", 32'(busy[0]), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        fill_mixed();
        exp_q[0].push_back(mixed_exp);
        send_frame(0, 4, 0);
        wait_idle(0);

        // SHIFT=4: per-neuron bias, saturation after the shift, floor on negatives
        fill(8'h10, 8'h02, 8'h00);
        fb[0] = 8'h10; fb[1] = 8'h20; fb[2] = 8'hF0; fb[3] = 8'h00;
        exp_q[1].push_back(32'h100F1211);
        send_frame(1, 4, 0);
        wait_idle(1);
        fill(8'h7F, 8'h7F, 8'h00);
        exp_q[1].push_back(32'h7F7F7F7F);
        send_frame(1, 4, 0);
        wait_idle(1);
        fill(8'h80, 8'h7F, 8'h00);
        exp_q[1].push_back(neg_exp);
        send_frame(1, 4, 0);
        wait_idle(1);
        fill(8'h01, 8'hFF, 8'h00);
        exp_q[1].push_back(neg1_exp);
        send_frame(1, 4, 0);
        wait_idle(1);

        // OUT_SIZE=8: backpressure hold, return to LOAD_IN, back-to-back frame
        t_ready[2] = 1'b0;
        fill(8'h01, 8'h00, 8'h00);
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < 8; i++) fw[j*8+i] = 8'(j + 1);
        exp_q[2].push_back(32'h20181008);
        exp_q[2].push_back(32'h40383028);
        send_frame(2, 8, 0);
        n = 0;
        while (!t_valid[2] && n < 200) begin
            tick();
            n++;
        end
        cap = out_data[2];
        stable_bad = 0;
        repeat (5) begin
            tick();
            if (!t_valid[2] || out_data[2] !== cap) stable_bad = 1;
        end
        check("held word stable", 32'(stable_bad), 32'd0);
        check("held word value", cap, 32'h20181008);
        t_ready[2] = 1'b1;
        hs = 0; n = 0;
        while (hs < 2 && n < 100) begin
            @(negedge clk);
            if (t_valid[2] && t_ready[2]) hs++;
            tick();
            n++;
        end
        check("out handshakes", 32'(hs), 32'd2);
        check("t_valid after last word", 32'(t_valid[2]), 32'd0);
        check("r_ready after last word", 32'(r_ready[2]), 32'd1);
        check("busy after last word", 32'(busy[2]), 32'd0);
        fill(8'h02, 8'h00, 8'h00);
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < 8; i++) fw[j*8+i] = 8'(j + 1);
        exp_q[2].push_back(32'h40302010);
        exp_q[2].push_back(32'h7F706050);
        send_frame(2, 8, 0);
        wait_idle(2);

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_stream_engine.md
Name: fc_stream_engine

Overview:
- Parametrised int8 fully-connected layer engine, successor to the fixed 8-in/4-out sample controller.
- Accepts input vector, weight matrix and bias over one 32-bit little-endian word stream with ready/valid flow control.
- Computes y[j] = sat8(((sum_i x[i]*w[j][i]) + b[j]) >>> SHIFT) on a single sequential MAC.
- Returns packed int8 results over a 32-bit output stream with backpressure; sits between the host DMA shim and the result collector.

Parameters:
- IN_SIZE, 8, input vector length in bytes; multiple of 4, range 4..256.
- OUT_SIZE, 4, output vector length in bytes; multiple of 4, range 4..64.
- SHIFT, 0, arithmetic right shift applied after bias add, range 0..15.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- r_valid  input  1  in_data word valid.
- r_ready  output  1  engine accepts in_data this cycle.
- in_data  input  32  stream word; byte k of the stream sits at bits [8k+7:8k] of its word (little-endian).
- t_valid  output  1  out_data holds a result word.
- t_ready  input  1  downstream accepts out_data.
- out_data  output  32  four packed int8 results, lowest-index result in bits [7:0].
- busy  output  1  high in COMPUTE and OUTPUT.

Behaviour:
- Reset (async assert, sync release): state LOAD_IN; r_ready=0 during reset, 1 on the first clock after release; t_valid=0; out_data=0; busy=0; all counters and buffers cleared.
- Transfer rules:
  - A word transfers when r_valid & r_ready at posedge.
  - r_valid while r_ready=0 is ignored; no buffering.
  - An output word transfers when t_valid & t_ready.
- Stream order:
  - IN_SIZE/4 input words, then IN_SIZE*OUT_SIZE/4 weight words, then OUT_SIZE/4 bias words.
  - Weights are row-major: stream byte j*IN_SIZE+i is w[j][i].
- States:
  - LOAD_IN, LOAD_W, LOAD_B: r_ready=1.
    - Each state advances after its last word is accepted.
    - Word counters reset on entry to each state.
  - COMPUTE: r_ready=0.
    - One signed 8x8 MAC per cycle; lasts exactly IN_SIZE*OUT_SIZE cycles.
    - Accumulator width ACC_W = 16+$clog2(IN_SIZE)+1; it cannot overflow.
    - On the last MAC of neuron j, sign-extended b[j] is added to the final sum in the same cycle. The result is then shifted arithmetic right by SHIFT, saturated to [-128,127], and written to result buffer byte j.
    - The accumulator clears for neuron j+1.
  - OUTPUT:
    - t_valid=1 from the cycle after COMPUTE ends; word 0 is presented first.
    - out_data and t_valid stay stable while t_ready=0.
    - After OUTPUT_SIZE/4 accepted words, the cycle after the last handshake has t_valid=0, state LOAD_IN, r_ready=1.
- Latency: the first t_valid rises IN_SIZE*OUT_SIZE+1 cycles after the last bias word handshake.
- Boundary rules:
  - Back-to-back frames are supported with no idle cycle beyond the OUTPUT-to-LOAD_IN transition.
  - rstn asserted mid-load, mid-compute or mid-output aborts the frame immediately. Partial data is discarded and the next frame starts at input word 0.
  - A t_ready held high across the final word does not cause a double transfer.
  - Saturation is applied after the shift, never before.

Optional Feature:
- RELU_EN:
  - Defined: negative saturated results are clamped to 0 before writing the result buffer.
  - Undefined: results pass unchanged, so -128..127 is possible.
  - The macro does not affect timing.

Decomposition:
- Package fc_stream_pkg:
  - State enum (LOAD_IN, LOAD_W, LOAD_B, COMPUTE, OUTPUT).
  - Localparam helpers: ACC_W function, words-per-section functions.
  - sat8 function (signed ACC_W to int8).
- Sub-module fc_mac:
  - Signed 8x8 multiply-accumulate with clear, bias-add and finalize strobe.
  - Outputs the shifted, saturated int8 result; registered accumulator.
- Top level holds the FSM, counters, and input/weight/bias/result buffers.

Test Plan:
- Default params, SHIFT=0: x=all 0x01, w=all 0x01, b=all 0x00 -> single out word 0x08080808; t_valid exactly 33 cycles after the last bias handshake.
- x=all 0x7F, w=all 0x7F, b=all 0x7F -> 0x7F7F7F7F (positive saturation). x=all 0x80, w=all 0x7F, b=0 -> 0x80808080 without RELU_EN, 0x00000000 with it.
- SHIFT=4, x=all 0x10, w=all 0x02, b=0x10,0x20,0xF0,0x00 -> sum 256 per neuron; results (256+b)>>>4 = 0x11,0x12,0x0F,0x10 -> out_data 0x100F1211.
- OUT_SIZE=8, t_ready low 5 cycles while t_valid high -> out_data and t_valid stable. After two accepted words the engine returns to LOAD_IN with r_ready=1 the next cycle; a second frame run back-to-back gives the correct result.
- r_valid toggled randomly during load -> result identical to a gap-free load. Reset pulsed after 3 weight words, then a full frame -> correct result with no stale data. r_valid during COMPUTE -> ignored, r_ready=0.
